// File: rtl/mfp_ahb_intc.sv
// AHB-Lite interrupt controller: synchronised sources, per-source edge/level mode and polarity,
// W1C pending bits, software set, and a registered combined request with lowest-index vector.
module mfp_ahb_intc #(
    parameter int unsigned N_SRC       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [2:0]       HSIZE,
    input  logic [31:0]      HWDATA,
    input  logic             HREADY,
    output logic [31:0]      HRDATA,
    output logic             HREADYOUT,
    output logic             HRESP,
    input  logic [N_SRC-1:0] IRQ_SRC,
    output logic             IRQ,
    output logic [4:0]       IRQ_ID
);

    typedef enum logic [2:0] {
        A_RAW, A_PEND, A_MASK, A_MODE, A_POL, A_VEC, A_SWSET, A_RSVD
    } reg_sel_e;

    localparam logic [31:0] VALID = (N_SRC >= 32) ? 32'hFFFF_FFFF : ((32'd1 << N_SRC) - 32'd1);

    logic [N_SRC-1:0]       sync_q [SYNC_STAGES];
    logic [N_SRC-1:0]       sync_d [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] vld_q, vld_d;
    logic [31:0]            hist_q, hist_d, armed_q, armed_d;
    logic [31:0]            pend_q, pend_d, mask_q, mask_d, mode_q, mode_d, pol_q, pol_d;
    logic                   wr_q, wr_d, rd_q, rd_d;
    reg_sel_e               addr_q, addr_d;
    logic                   irq_q, irq_d;
    logic [4:0]             id_q, id_d;

    logic [31:0] raw, active, edge_set, wdata, w1c, swset, masked;
    logic        addr_ph, found;
    logic        unused_bus;

    assign unused_bus = ^{HSIZE, HADDR[31:5], HADDR[1:0], HTRANS[0]};

    always_comb begin
        sync_d[0] = IRQ_SRC;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        vld_d = {vld_q[SYNC_STAGES-2:0], 1'b1};

        raw    = 32'(sync_q[SYNC_STAGES-1]);
        active = (raw ^ pol_q) & VALID;

        // A source only arms once a genuine (post-fill) sample has shown it inactive.
        armed_d  = (armed_q | (~active & {32{vld_q[SYNC_STAGES-1]}})) & VALID;
        edge_set = active & ~hist_q & armed_q;

        addr_ph = HSEL & HTRANS[1] & HREADY;
        wr_d    = addr_ph & HWRITE;
        rd_d    = addr_ph & ~HWRITE;
        addr_d  = addr_ph ? reg_sel_e'(HADDR[4:2]) : addr_q;

        wdata  = HWDATA & VALID;
        mask_d = mask_q;
        mode_d = mode_q;
        pol_d  = pol_q;
        w1c    = '0;
        swset  = '0;
        if (wr_q) begin
            case (addr_q)
                A_PEND:  w1c    = wdata;
                A_MASK:  mask_d = wdata;
                A_MODE:  mode_d = wdata;
                A_POL:   pol_d  = wdata;
                A_SWSET: swset  = wdata;
                default: ;
            endcase
        end

        // History uses the polarity in force next cycle, so a POL write never looks like an edge.
        hist_d = (raw ^ pol_d) & VALID;

        pend_d = ((mode_q & ((pend_q & ~w1c) | edge_set | swset)) | (~mode_q & active)) & VALID;

        // The incoming MASK value is used so a MASK write reaches IRQ one cycle after its data phase.
        masked = pend_q & mask_d;
        irq_d  = |masked;
        id_d   = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (masked[i] && !found) begin
                id_d  = 5'(i);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync_q  <= '{default: '0};
            vld_q   <= '0;
            hist_q  <= '0;
            armed_q <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            mode_q  <= '0;
            pol_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= A_RAW;
            irq_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            sync_q  <= sync_d;
            vld_q   <= vld_d;
            hist_q  <= hist_d;
            armed_q <= armed_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            pol_q   <= pol_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            irq_q   <= irq_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        HRDATA = '0;
        if (rd_q) begin
            case (addr_q)
                A_RAW:   HRDATA = raw;
                A_PEND:  HRDATA = pend_q;
                A_MASK:  HRDATA = mask_q;
                A_MODE:  HRDATA = mode_q;
                A_POL:   HRDATA = pol_q;
                A_VEC:   HRDATA = {irq_q, 26'd0, id_q};
                default: HRDATA = '0;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign IRQ       = irq_q;
    assign IRQ_ID    = id_q;

endmodule

// File: tb/tb_mfp_ahb_intc.sv
// Bench for mfp_ahb_intc: directed scenarios plus randomized bus/source traffic, all checked
// every cycle against a rule-level model of the register file and interrupt logic.
module tb_mfp_ahb_intc;

    localparam int S = 2;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = '0;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'd2;
    logic [31:0] HWDATA = '0;
    logic        HREADY = 1'b1;
    logic [7:0]  IRQ_SRC = '0;

    logic [31:0] HRDATA, HRDATA4;
    logic        HREADYOUT, HRESP, IRQ, HREADYOUT4, HRESP4, IRQ4;
    logic [4:0]  IRQ_ID, IRQ_ID4;

    int n_checks = 0;
    int n_pass = 0;

    always #5 HCLK = ~HCLK;

    mfp_ahb_intc #(.N_SRC(8), .SYNC_STAGES(S)) u_dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .IRQ_SRC(IRQ_SRC), .IRQ(IRQ), .IRQ_ID(IRQ_ID)
    );

    mfp_ahb_intc #(.N_SRC(4), .SYNC_STAGES(S)) u_dut4 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA4),
        .HREADYOUT(HREADYOUT4), .HRESP(HRESP4), .IRQ_SRC(IRQ_SRC[3:0]), .IRQ(IRQ4), .IRQ_ID(IRQ_ID4)
    );

    // Model state for the 8-source instance
    logic [7:0] m_sh [S];
    int         m_cnt;
    logic [7:0] m_prev_raw, m_armed, m_pend, m_mask, m_mode, m_pol;
    logic       m_irq, m_wr, m_rd;
    logic [4:0] m_id;
    logic [2:0] m_addr;

    logic [7:0]  m_raw, m_act, m_edge, m_w1c, m_sw, m_mask_nx, m_pend_nx;
    logic [4:0]  m_id_nx;
    logic [31:0] m_rdata;

    always_comb begin
        m_raw     = m_sh[S-1];
        m_act     = m_raw ^ m_pol;
        // rising of "active" as judged through whatever polarity is currently programmed
        m_edge    = m_act & ~(m_prev_raw ^ m_pol) & m_armed;
        m_w1c     = (m_wr && m_addr == 3'd1) ? HWDATA[7:0] : 8'h00;
        m_sw      = (m_wr && m_addr == 3'd6) ? HWDATA[7:0] : 8'h00;
        m_mask_nx = (m_wr && m_addr == 3'd2) ? HWDATA[7:0] : m_mask;
        m_pend_nx = '0;
        for (int n = 0; n < 8; n++) begin
            if (m_mode[n]) m_pend_nx[n] = m_edge[n] | m_sw[n] | (m_pend[n] & ~m_w1c[n]);
            else           m_pend_nx[n] = m_act[n];
        end
        m_id_nx = '0;
        for (int n = 7; n >= 0; n--) begin
            if (m_pend[n] & m_mask_nx[n]) m_id_nx = 5'(n);
        end
        m_rdata = '0;
        if (m_rd) begin
            case (m_addr)
                3'd0:    m_rdata = {24'd0, m_raw};
                3'd1:    m_rdata = {24'd0, m_pend};
                3'd2:    m_rdata = {24'd0, m_mask};
                3'd3:    m_rdata = {24'd0, m_mode};
                3'd4:    m_rdata = {24'd0, m_pol};
                3'd5:    m_rdata = {m_irq, 26'd0, m_id};
                default: m_rdata = '0;
            endcase
        end
    end

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_sh       <= '{default: '0};
            m_cnt      <= 0;
            m_prev_raw <= '0;
            m_armed    <= '0;
            m_pend     <= '0;
            m_mask     <= '0;
            m_mode     <= '0;
            m_pol      <= '0;
            m_irq      <= 1'b0;
            m_id       <= '0;
            m_wr       <= 1'b0;
            m_rd       <= 1'b0;
            m_addr     <= '0;
        end else begin
            m_sh[0] <= IRQ_SRC;
            for (int i = 1; i < S; i++) m_sh[i] <= m_sh[i-1];
            if (m_cnt < S) m_cnt <= m_cnt + 1;
            m_prev_raw <= m_raw;
            m_armed    <= m_armed | ((m_cnt >= S) ? ~m_act : 8'h00);
            m_pend     <= m_pend_nx;
            m_mask     <= m_mask_nx;
            if (m_wr && m_addr == 3'd3) m_mode <= HWDATA[7:0];
            if (m_wr && m_addr == 3'd4) m_pol  <= HWDATA[7:0];
            m_irq <= |(m_pend & m_mask_nx);
            m_id  <= m_id_nx;
            m_wr  <= HSEL & HTRANS[1] & HWRITE & HREADY;
            m_rd  <= HSEL & HTRANS[1] & ~HWRITE & HREADY;
            if (HSEL & HTRANS[1] & HREADY) m_addr <= HADDR[4:2];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    always @(negedge HCLK) begin
        check("irq", 32'(IRQ), 32'(m_irq));
        check("irq_id", 32'(IRQ_ID), 32'(m_id));
        check("hrdata", HRDATA, m_rdata);
        check("hreadyout", 32'(HREADYOUT), 32'd1);
        check("hresp", 32'(HRESP), 32'd0);
    end

    task automatic tick();
        @(negedge HCLK);
        #1;
    endtask

    task automatic idle_bus();
        logic [31:0] r;
        r      = $urandom;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HREADY = 1'b1;
        HADDR  = r;
        HWDATA = $urandom;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a; HREADY = 1'b1;
        tick();
        idle_bus();
        HWDATA = d;
        tick();
        HWDATA = $urandom;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a; HREADY = 1'b1;
        tick();
        idle_bus();
        check(name, HRDATA, exp);
        tick();
    endtask

    initial begin
        logic [31:0] r;
        idle_bus();
        HRESETn = 1'b0;
        repeat (3) tick();
        HRESETn = 1'b1;
        tick();
        rd(32'h08, 32'h0, "mask_rst");
        rd(32'h14, 32'h0, "vec_rst");
        wr(32'h1C, 32'hFFFF_FFFF);
        rd(32'h1C, 32'h0, "rsvd_read");

        // single-cycle edge pulse on source 0, latency and W1C
        wr(32'h08, 32'h1);
        wr(32'h0C, 32'h1);
        IRQ_SRC[0] = 1'b1;
        tick();
        IRQ_SRC[0] = 1'b0;
        tick(); tick();
        check("irq_lat3", 32'(IRQ), 32'd0);
        tick();
        check("irq_lat4", 32'(IRQ), 32'd1);
        check("irq_id_src0", 32'(IRQ_ID), 32'd0);
        rd(32'h04, 32'h1, "pend_edge0");
        rd(32'h14, 32'h8000_0000, "vec_src0");
        wr(32'h04, 32'h1);
        check("irq_w1c_1", 32'(IRQ), 32'd1);
        tick();
        check("irq_w1c_2", 32'(IRQ), 32'd0);

        // level sources and priority
        wr(32'h0C, 32'h0);
        wr(32'h08, 32'hFF);
        IRQ_SRC = 8'h24;
        repeat (5) tick();
        check("lvl_id2", 32'(IRQ_ID), 32'd2);
        IRQ_SRC = 8'h20;
        repeat (5) tick();
        check("lvl_id5", 32'(IRQ_ID), 32'd5);
        IRQ_SRC = 8'h00;
        repeat (5) tick();
        check("lvl_irq0", 32'(IRQ), 32'd0);

        // falling-edge source 3; POL change must not create an edge
        wr(32'h0C, 32'h8);
        wr(32'h10, 32'h8);
        wr(32'h08, 32'h8);
        repeat (3) tick();
        rd(32'h04, 32'h0, "pol_no_spur");
        IRQ_SRC[3] = 1'b1;
        repeat (5) tick();
        rd(32'h00, 32'h8, "raw3");
        rd(32'h04, 32'h0, "rise_ignored");
        IRQ_SRC[3] = 1'b0;
        repeat (5) tick();
        rd(32'h04, 32'h8, "pend_fall3");
        rd(32'h14, 32'h8000_0003, "vec_src3");
        wr(32'h0C, 32'h0);
        wr(32'h10, 32'h0);
        repeat (2) tick();

        // set beats W1C on the same bit in the same cycle
        wr(32'h0C, 32'h2);
        wr(32'h08, 32'h2);
        IRQ_SRC[1] = 1'b1;
        tick();
        IRQ_SRC[1] = 1'b0;
        repeat (4) tick();
        rd(32'h04, 32'h2, "pend1_set");
        IRQ_SRC[1] = 1'b1;
        tick();
        IRQ_SRC[1] = 1'b0;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h04;
        tick();
        idle_bus();
        HWDATA = 32'h2;
        tick();
        HWDATA = $urandom;
        rd(32'h04, 32'h2, "pend1_collide");
        wr(32'h04, 32'h2);
        rd(32'h04, 32'h0, "pend1_w1c");

        // SWSET only affects edge-mode bits; back-to-back write/read
        wr(32'h0C, 32'h1);
        wr(32'h18, 32'h3);
        rd(32'h04, 32'h1, "swset_edge_only");
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h08;
        tick();
        HWRITE = 1'b0; HTRANS = 2'b11; HWDATA = 32'h5A;
        tick();
        idle_bus();
        check("b2b_mask", HRDATA, 32'h5A);
        check("b2b_hresp", 32'(HRESP), 32'd0);
        check("b2b_hready", 32'(HREADYOUT), 32'd1);
        tick();
        wr(32'h04, 32'hFF);

        // randomized traffic, model checked every cycle
        for (int i = 0; i < 3000; i++) begin
            r      = $urandom;
            HSEL   = (r[1:0] != 2'b00);
            HTRANS = r[3:2];
            HWRITE = r[4];
            HREADY = (r[7:5] != 3'b000);
            HADDR  = {r[31:13], r[12:8], 2'b00} ^ {27'd0, r[10:8], 2'b00};
            HWDATA = $urandom;
            if (r[14:12] == 3'b000) IRQ_SRC[r[17:15]] = ~IRQ_SRC[r[17:15]];
            tick();
        end
        idle_bus();
        IRQ_SRC = '0;
        repeat (4) tick();

        // 4-source instance: unimplemented bits, then reset mid-write
        wr(32'h08, 32'hFFFF_FFFF);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h08;
        tick();
        idle_bus();
        check("mask4_trunc", HRDATA4, 32'h0000_000F);
        check("mask8_trunc", HRDATA, 32'h0000_00FF);
        tick();
        HSEL = 1'b1; HTRANS = 2'b11; HWRITE = 1'b1; HADDR = 32'h0C;
        tick();
        idle_bus();
        HWDATA = 32'hFFFF_FFFF;
        HRESETn = 1'b0;
        tick();
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_hready4", 32'(HREADYOUT4), 32'd1);
        tick();
        HRESETn = 1'b1;
        tick();
        for (int a = 0; a < 6; a++) begin
            HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'(a * 4);
            tick();
            idle_bus();
            check("rst4_reg", HRDATA4, 32'h0);
            tick();
        end
        check("rst4_irq", 32'(IRQ4), 32'd0);
        check("rst4_id", 32'(IRQ_ID4), 32'd0);
        check("rst4_hresp", 32'(HRESP4), 32'd0);

        // source high across reset release must be seen low before it can latch
        IRQ_SRC = 8'h01;
        HRESETn = 1'b0;
        tick(); tick();
        HRESETn = 1'b1;
        wr(32'h0C, 32'h1);
        wr(32'h08, 32'h1);
        repeat (4) tick();
        rd(32'h04, 32'h0, "no_edge_after_rst");
        check("no_irq_after_rst", 32'(IRQ), 32'd0);
        IRQ_SRC = 8'h00;
        repeat (4) tick();
        IRQ_SRC = 8'h01;
        repeat (5) tick();
        rd(32'h04, 32'h1, "edge_after_low");
        check("irq_after_low", 32'(IRQ), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
